sysa_array: RTL and testbench



---
 rtl/sysa_array.sv | 148 ++++++++++++++
 tb/tb_sysa_array.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysa_array.sv
// ---------------------------------------------------------------------------
// sysa_array -- 3x3 weight-stationary systolic array (edu TPU compute core)
//
// Each advancing cycle (en=1) consumes one input word holding three DW-bit
// lanes.  A word with w=1 loads one weight row (row index from an internal
// load counter that wraps 0,1,2); a word with w=0 is one activation vector.
// Vectors are supplied unskewed; lane r is delayed r cycles internally so
// that the diagonal wavefront lines up with the partial sums flowing down.
//
// Latency (advancing edges): vector captured at edge t -> out1 after t+3,
// out2 after t+4, out3 after t+5.  Back-to-back vectors give one result per
// cycle per column.
//
// Ports:
//   clk   in   1   rising-edge clock
//   rst   in   1   asynchronous active-high reset, clears all state
//   en    in   1   global advance; 0 freezes everything
//   w     in   1   1 = weight-load word, 0 = activation vector
//   in    in   32  lane r = in[8r+7:8r]; in[31:24] unused
//   out1  out  OW  column 0 dot product
//   out2  out  OW  column 1 dot product
//   out3  out  OW  column 2 dot product
//
// Build option: define SIGNED_EN to treat lanes and weights as two's
// complement (products sign-extended); otherwise everything is unsigned.
// Arithmetic always wraps modulo 2^OW.  The skew line is written for N=3.
// ---------------------------------------------------------------------------
module sysa_array #(
    parameter int DW = 8,
    parameter int OW = 16,
    parameter int N  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          w,
    input  logic [31:0]   in,
    output logic [OW-1:0] out1,
    output logic [OW-1:0] out2,
    output logic [OW-1:0] out3
);

    // Lanes entering the array: zero activations are injected on load cycles.
    logic [DW-1:0] lane0, lane1, lane2;
    // Input skew registers: lane 1 delayed once, lane 2 twice.
    logic [DW-1:0] sk1, sk2_0, sk2_1;
    // Weight-row load counter.
    logic [1:0]    lc;

    // Activation arriving at each PE and partial sum leaving each PE.
    logic [DW-1:0] a_in [N][N];
    logic [OW-1:0] psum [N][N];

    logic unused_in;
    assign unused_in = ^in[31:3*DW];

    always_comb begin
        lane0 = w ? '0 : in[DW-1:0];
        lane1 = w ? '0 : in[2*DW-1:DW];
        lane2 = w ? '0 : in[3*DW-1:2*DW];
    end

    // Column 0 of each row is fed by the skew line for that lane.
    assign a_in[0][0] = lane0;
    assign a_in[1][0] = sk1;
    assign a_in[2][0] = sk2_1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sk1   <= '0;
            sk2_0 <= '0;
            sk2_1 <= '0;
            lc    <= '0;
            out1  <= '0;
            out2  <= '0;
            out3  <= '0;
        end else if (en) begin
            sk1   <= lane1;
            sk2_0 <= lane2;
            sk2_1 <= sk2_0;
            // Any activation cycle restarts row loading at row 0.
            if (w) begin
                lc <= (lc == 2'd2) ? 2'd0 : lc + 2'd1;
            end else begin
                lc <= 2'd0;
            end
            out1 <= psum[N-1][0];
            out2 <= psum[N-1][1];
            out3 <= psum[N-1][2];
        end
    end

    genvar r, c;
    generate
        for (r = 0; r < N; r++) begin : g_row
            for (c = 0; c < N; c++) begin : g_col
                logic [DW-1:0] wq;
                logic [OW-1:0] p_q;
                logic [OW-1:0] p_in;
                logic [OW-1:0] prod;

                if (r == 0) begin : g_top
                    assign p_in = '0;
                end else begin : g_mid
                    assign p_in = psum[r-1][c];
                end

                // Widen both operands to OW first so the low OW bits of the
                // product are correct for either signedness.
`ifdef SIGNED_EN
                assign prod = {{(OW-DW){a_in[r][c][DW-1]}}, a_in[r][c]} *
                              {{(OW-DW){wq[DW-1]}}, wq};
`else
                assign prod = {{(OW-DW){1'b0}}, a_in[r][c]} *
                              {{(OW-DW){1'b0}}, wq};
`endif

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        wq  <= '0;
                        p_q <= '0;
                    end else if (en) begin
                        if (w && (lc == 2'(r))) begin
                            wq <= in[DW*c +: DW];
                        end
                        p_q <= p_in + prod;
                    end
                end

                assign psum[r][c] = p_q;

                // Rightmost column has nobody to pass its activation to.
                if (c < N-1) begin : g_act
                    logic [DW-1:0] a_q;
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            a_q <= '0;
                        end else if (en) begin
                            a_q <= a_in[r][c];
                        end
                    end
                    assign a_in[r][c+1] = a_q;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sysa_array.sv
// ---------------------------------------------------------------------------
// tb_sysa_array -- scoreboard bench for sysa_array.
// The driver pushes, per advancing cycle, the expected column results into
// per-column queues (prefilled with the pipeline-depth zeros seen after
// reset); a monitor pops one entry per column on every advancing edge and
// checks holds on stalled edges.  Results are also logged per advancing edge
// so directed cases can check absolute values at the required latency.
// ---------------------------------------------------------------------------
module tb_sysa_array;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        w;
  logic [31:0] in;
  logic [15:0] out1, out2, out3;

  sysa_array dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .w    (w),
    .in   (in),
    .out1 (out1),
    .out2 (out2),
    .out3 (out3)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];

  logic [7:0]  mw [3][3];
  int          lc_m;
  int          issued = 0;
  int          adv = 0;
  int          last_idx;
  logic [15:0] h1 [0:4095];
  logic [15:0] h2 [0:4095];
  logic [15:0] h3 [0:4095];
  logic [15:0] last1, last2, last3;

`ifdef SIGNED_EN
  localparam logic [15:0] OVF_EXP = 16'd3;
`else
  localparam logic [15:0] OVF_EXP = 16'hFA03;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Column dot product of a vector with the model's weight matrix, mod 2^16.
  function automatic logic [15:0] dot(input int col, input logic [23:0] d);
    int s = 0;
    for (int r = 0; r < 3; r++) begin
`ifdef SIGNED_EN
      s += int'($signed(d[8*r +: 8])) * int'($signed(mw[r][col]));
`else
      s += int'(d[8*r +: 8]) * int'(mw[r][col]);
`endif
    end
    return s[15:0];
  endfunction

  task automatic clear_model();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    repeat (3) exp_q0.push_back(16'd0);
    repeat (4) exp_q1.push_back(16'd0);
    repeat (5) exp_q2.push_back(16'd0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        mw[r][c] = 8'd0;
    lc_m  = 0;
    last1 = 16'd0;
    last2 = 16'd0;
    last3 = 16'd0;
  endtask

  // One cycle of stimulus; the edge that consumes it follows this negedge.
  task automatic drive(input logic e, input logic wv, input logic [31:0] d);
    @(negedge clk);
    en = e;
    w  = wv;
    in = d;
    last_idx = -1;
    if (e) begin
      issued++;
      last_idx = issued;
      if (wv) begin
        exp_q0.push_back(16'd0);
        exp_q1.push_back(16'd0);
        exp_q2.push_back(16'd0);
        for (int c = 0; c < 3; c++) mw[lc_m][c] = d[8*c +: 8];
        lc_m = (lc_m + 1) % 3;
      end else begin
        exp_q0.push_back(dot(0, d[23:0]));
        exp_q1.push_back(dot(1, d[23:0]));
        exp_q2.push_back(dot(2, d[23:0]));
        lc_m = 0;
      end
    end
  endtask

  task automatic load3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    drive(1'b1, 1'b1, a);
    drive(1'b1, 1'b1, b);
    drive(1'b1, 1'b1, c);
  endtask

  // Drain in-flight vectors, then leave the array stalled.
  task automatic flush();
    repeat (6) drive(1'b1, 1'b0, {8'($urandom_range(0, 255)), 24'd0});
    drive(1'b0, 1'b0, 32'd0);
  endtask

  task automatic chk_hist(input string name, input int idx, input int col, input logic [15:0] exp);
    if (col == 0) check(name, h1[idx], exp);
    else if (col == 1) check(name, h2[idx], exp);
    else check(name, h3[idx], exp);
  endtask

  task automatic pop_chk(input string name, input int col, input logic [15:0] act);
    logic [15:0] e;
    int sz;
    sz = (col == 0) ? exp_q0.size() : (col == 1) ? exp_q1.size() : exp_q2.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %h with no expected entry", name, act);
    end else begin
      if (col == 0) e = exp_q0.pop_front();
      else if (col == 1) e = exp_q1.pop_front();
      else e = exp_q2.pop_front();
      check(name, act, e);
    end
  endtask

  // Monitor: samples 1ns after each rising edge.
  initial begin
    logic e_s, r_s;
    forever begin
      @(posedge clk);
      e_s = en;
      r_s = rst;
      #1;
      if (!r_s) begin
        if (e_s) begin
          adv++;
          pop_chk("sb_out1", 0, out1);
          pop_chk("sb_out2", 1, out2);
          pop_chk("sb_out3", 2, out3);
          h1[adv] = out1;
          h2[adv] = out2;
          h3[adv] = out3;
        end else begin
          check("hold_out1", out1, last1);
          check("hold_out2", out2, last2);
          check("hold_out3", out3, last3);
        end
        last1 = out1;
        last2 = out2;
        last3 = out3;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1;
    en  = 1'b0;
    w   = 1'b0;
    in  = 32'd0;
    clear_model();
    repeat (2) @(negedge clk);
    check("reset_out1", out1, 16'd0);
    check("reset_out2", out2, 16'd0);
    check("reset_out3", out3, 16'd0);
    rst = 1'b0;

    // Identity weights.
    load3(32'h000001, 32'h000100, 32'h010000);
    drive(1'b1, 1'b0, 32'h030201);
    t = last_idx;
    flush();
    chk_hist("ident_out1", t + 3, 0, 16'd1);
    chk_hist("ident_out2", t + 4, 1, 16'd2);
    chk_hist("ident_out3", t + 5, 2, 16'd3);

    // All-ones weights.
    load3(32'h010101, 32'h010101, 32'h010101);
    drive(1'b1, 1'b0, 32'hAB030201);
    t = last_idx;
    flush();
    chk_hist("ones_out1", t + 3, 0, 16'd6);
    chk_hist("ones_out2", t + 4, 1, 16'd6);
    chk_hist("ones_out3", t + 5, 2, 16'd6);

    // Wrap-around on maximum operands.
    load3(32'hFFFFFF, 32'hFFFFFF, 32'hFFFFFF);
    drive(1'b1, 1'b0, 32'hFFFFFF);
    t = last_idx;
    flush();
    chk_hist("ovf_out1", t + 3, 0, OVF_EXP);
    chk_hist("ovf_out2", t + 4, 1, OVF_EXP);
    chk_hist("ovf_out3", t + 5, 2, OVF_EXP);

    // Streaming with identity weights.
    load3(32'h000001, 32'h000100, 32'h010000);
    drive(1'b1, 1'b0, 32'h030201);
    t = last_idx;
    drive(1'b1, 1'b0, 32'h060504);
    drive(1'b1, 1'b0, 32'h090807);
    flush();
    for (int k = 0; k < 3; k++) begin
      chk_hist("stream_out1", t + 3 + k, 0, 16'(3 * k + 1));
      chk_hist("stream_out2", t + 4 + k, 1, 16'(3 * k + 2));
      chk_hist("stream_out3", t + 5 + k, 2, 16'(3 * k + 3));
    end

    // Stall mid-stream: four en=0 cycles with garbage on the inputs.
    drive(1'b1, 1'b0, 32'h030201);
    t = last_idx;
    drive(1'b1, 1'b0, 32'h060504);
    repeat (4) drive(1'b0, 1'($urandom_range(0, 1)), $urandom);
    flush();
    chk_hist("stall_out1", t + 3, 0, 16'd1);
    chk_hist("stall_out2", t + 4, 1, 16'd2);
    chk_hist("stall_out3", t + 5, 2, 16'd3);
    chk_hist("stall_out1b", t + 4, 0, 16'd4);

    // Asynchronous reset mid-stream.
    load3(32'h010101, 32'h010101, 32'h010101);
    drive(1'b1, 1'b0, 32'h030201);
    drive(1'b1, 1'b0, 32'h060504);
    drive(1'b1, 1'b0, 32'h090807);
    drive(1'b1, 1'b0, 32'h0A0B0C);
    @(posedge clk);
    #3;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check("midrst_out1", out1, 16'd0);
    check("midrst_out2", out2, 16'd0);
    check("midrst_out3", out3, 16'd0);
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Weights were cleared: a vector without reload must give zero.
    drive(1'b1, 1'b0, 32'h030201);
    t = last_idx;
    flush();
    chk_hist("postrst_out1", t + 3, 0, 16'd0);
    chk_hist("postrst_out3", t + 5, 2, 16'd0);

    // Randomized rounds checked by the scoreboard.
    for (int round = 0; round < 6; round++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b1, $urandom);
        drive(1'b1, 1'b1, $urandom);
      end
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 4) == 0) drive(1'b0, 1'($urandom_range(0, 1)), $urandom);
        drive(1'b1, 1'b0, $urandom);
      end
      flush();
    end

    drive(1'b0, 1'b0, 32'd0);
    check("q0_depth", 16'(exp_q0.size()), 16'd3);
    check("q1_depth", 16'(exp_q1.size()), 16'd4);
    check("q2_depth", 16'(exp_q2.size()), 16'd5);
    check("edge_count", 16'(adv), 16'(issued));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
